// File: rtl/find_stars_pkg.sv
// Shared constants and types for the star-finding datapath: framebuffer
// geometry, plot colours and the box-outline FSM state encoding.
package find_stars_pkg;

   localparam int XSZ      = 8;
   localparam int YSZ      = 7;
   localparam int X_MAX    = 159;
   localparam int Y_MAX    = 119;
   localparam int COLOUR_W = 3;

   localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
   localparam logic [COLOUR_W-1:0] RED   = 3'b100;
   localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_TOP    = 3'd1,
      S_RIGHT  = 3'd2,
      S_BOTTOM = 3'd3,
      S_LEFT   = 3'd4,
      S_DONE   = 3'd5
   } box_state_t;

endpackage

// File: rtl/star_box_draw.sv
// Traces a rectangle outline clockwise (top, right, bottom, left) one pixel
// per clock onto the VGA adapter plot port; corners are plotted exactly once.
module star_box_draw
   import find_stars_pkg::*;
#(
   parameter int                  XSZ        = find_stars_pkg::XSZ,
   parameter int                  YSZ        = find_stars_pkg::YSZ,
   parameter int                  X_MAX      = find_stars_pkg::X_MAX,
   parameter int                  Y_MAX      = find_stars_pkg::Y_MAX,
   parameter logic [COLOUR_W-1:0] BOX_COLOUR = RED
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                goDraw,
   input  logic                erase,
   input  logic [XSZ-1:0]      xLeft,
   input  logic [XSZ-1:0]      xRight,
   input  logic [YSZ-1:0]      yTop,
   input  logic [YSZ-1:0]      yBottom,
   output logic [XSZ-1:0]      x,
   output logic [YSZ-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                doneDraw
);

   localparam logic [XSZ-1:0] X_MAX_C = XSZ'(X_MAX);
   localparam logic [YSZ-1:0] Y_MAX_C = YSZ'(Y_MAX);
   localparam logic [XSZ-1:0] X_ONE   = XSZ'(1);
   localparam logic [YSZ-1:0] Y_ONE   = YSZ'(1);

   box_state_t     state_r;
   logic [XSZ-1:0] xl_r, xr_r;
   logic [YSZ-1:0] yt_r, yb_r;
   logic           invalid_s;

   // Box validity check on the live inputs, used only at acceptance.
   always_comb begin
      invalid_s = 1'b0;
      if ((xLeft > xRight) || (yTop > yBottom) ||
          (xRight > X_MAX_C) || (yBottom > Y_MAX_C)) begin
         invalid_s = 1'b1;
      end else begin
         invalid_s = 1'b0;
      end
   end

   // Outline FSM; the x/y outputs double as the edge counters, and every
   // edge ends on an equality compare so a zero bound never underflows.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= S_IDLE;
         x        <= '0;
         y        <= '0;
         colour   <= BLACK;
         plot     <= 1'b0;
         busy     <= 1'b0;
         doneDraw <= 1'b0;
         xl_r     <= '0;
         xr_r     <= '0;
         yt_r     <= '0;
         yb_r     <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (goDraw) begin
                  xl_r   <= xLeft;
                  xr_r   <= xRight;
                  yt_r   <= yTop;
                  yb_r   <= yBottom;
                  colour <= erase ? BLACK : BOX_COLOUR;
                  busy   <= 1'b1;
                  if (invalid_s) begin
                     state_r  <= S_DONE;
                     doneDraw <= 1'b1;
                  end else begin
                     state_r <= S_TOP;
                     x       <= xLeft;
                     y       <= yTop;
                     plot    <= 1'b1;
                  end
               end
            end
            S_TOP: begin
               if (x != xr_r) begin
                  x <= x + X_ONE;
               end else if (yt_r == yb_r) begin
                  state_r  <= S_DONE;
                  plot     <= 1'b0;
                  doneDraw <= 1'b1;
               end else begin
                  state_r <= S_RIGHT;
                  y       <= yt_r + Y_ONE;
               end
            end
            S_RIGHT: begin
               if (y != yb_r) begin
                  y <= y + Y_ONE;
               end else if (xl_r == xr_r) begin
                  state_r  <= S_DONE;
                  plot     <= 1'b0;
                  doneDraw <= 1'b1;
               end else begin
                  state_r <= S_BOTTOM;
                  x       <= xr_r - X_ONE;
               end
            end
            S_BOTTOM: begin
               if (x != xl_r) begin
                  x <= x - X_ONE;
               end else if (yb_r == yt_r + Y_ONE) begin
                  state_r  <= S_DONE;
                  plot     <= 1'b0;
                  doneDraw <= 1'b1;
               end else begin
                  state_r <= S_LEFT;
                  y       <= yb_r - Y_ONE;
               end
            end
            S_LEFT: begin
               if (y != yt_r + Y_ONE) begin
                  y <= y - Y_ONE;
               end else begin
                  state_r  <= S_DONE;
                  plot     <= 1'b0;
                  doneDraw <= 1'b1;
               end
            end
            S_DONE: begin
               if (!goDraw) begin
                  state_r  <= S_IDLE;
                  busy     <= 1'b0;
                  doneDraw <= 1'b0;
               end
            end
            default: begin
               state_r  <= S_IDLE;
               plot     <= 1'b0;
               busy     <= 1'b0;
               doneDraw <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_star_box_draw.sv
// Self-checking bench for star_box_draw: directed test-plan boxes plus
// random boxes compared against a pixel-list model of the outline.
module tb_star_box_draw;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       goDraw = 1'b0;
   logic       erase = 1'b0;
   logic [7:0] xLeft = 8'd0, xRight = 8'd0;
   logic [6:0] yTop = 7'd0, yBottom = 7'd0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, doneDraw;

   int passed = 0;
   int total  = 0;

   logic [14:0] exp_q[$];
   logic [14:0] got_q[$];
   int first_cyc, done_cyc, gaps, col_bad, busy_bad;
   bit hold_ok, release_ok;

   star_box_draw dut (
      .clk(clk), .reset(reset), .goDraw(goDraw), .erase(erase),
      .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
      .doneDraw(doneDraw)
   );

   always #5 clk = ~clk;

   // Reference outline: clockwise pixel list, no corner repeated.
   task automatic model_box(input int xl, input int xr, input int yt, input int yb);
      exp_q.delete();
      if (xl > xr || yt > yb || xr > 159 || yb > 119) return;
      for (int i = xl; i <= xr; i++) exp_q.push_back({8'(i), 7'(yt)});
      if (yb > yt) begin
         for (int j = yt + 1; j <= yb; j++) exp_q.push_back({8'(xr), 7'(j)});
         if (xr > xl) begin
            for (int i = xr - 1; i >= xl; i--) exp_q.push_back({8'(i), 7'(yb)});
            for (int j = yb - 1; j > yt; j--) exp_q.push_back({8'(xl), 7'(j)});
         end
      end
   endtask

   function automatic bit seq_equal();
      if (got_q.size() != exp_q.size()) return 1'b0;
      foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Drives one request and records what the DUT plots; optionally changes
   // xRight at cycle mod_cyc to probe immunity.
   task automatic run_box(input int xl, input int xr, input int yt, input int yb,
                          input bit er, input int mod_cyc, input int new_xr);
      logic [2:0] expcol;
      int last;
      expcol = er ? 3'b000 : 3'b100;
      @(negedge clk);
      xLeft = 8'(xl); xRight = 8'(xr); yTop = 7'(yt); yBottom = 7'(yb);
      erase = er; goDraw = 1'b1;
      first_cyc = -1; done_cyc = -1; gaps = 0; col_bad = 0; busy_bad = 0; last = -1;
      got_q.delete();
      for (int k = 1; k <= 600 && done_cyc < 0; k++) begin
         @(posedge clk); #1;
         if (plot) begin
            if (first_cyc < 0) first_cyc = k;
            else if (last != k - 1) gaps++;
            last = k;
            got_q.push_back({x, y});
            if (colour !== expcol) col_bad++;
         end
         if (busy !== 1'b1) busy_bad++;
         if (doneDraw) done_cyc = k;
         if (k == mod_cyc) begin
            xRight = 8'(new_xr);
            erase = ~er;
         end
      end
      hold_ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (doneDraw !== 1'b1 || plot !== 1'b0) hold_ok = 1'b0;
      end
      @(negedge clk); goDraw = 1'b0;
      @(posedge clk); #1;
      release_ok = (doneDraw === 1'b0) && (busy === 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1; goDraw = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({x, y, colour, plot, busy, doneDraw} !== 21'd0)
         $display("FAIL reset_values got x=%0d y=%0d c=%0d p=%b b=%b d=%b want all 0",
                  x, y, colour, plot, busy, doneDraw);
      else passed++;
      @(negedge clk); reset = 1'b0; goDraw = 1'b0;
      @(posedge clk); #1;
      total++;
      if (plot !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_priority got plot=%b busy=%b want 0 0", plot, busy);
      else passed++;
   endtask

   task automatic check_run(input string name, input int n_exp, input bit er);
      int exp_done;
      exp_done = n_exp + 1;
      total++;
      if (done_cyc !== exp_done)
         $display("FAIL %s_done_cycle got %0d want %0d", name, done_cyc, exp_done);
      else passed++;
      total++;
      if (!seq_equal())
         $display("FAIL %s_pixels got %0d pixels want %0d (order/coords differ)",
                  name, got_q.size(), exp_q.size());
      else passed++;
      total++;
      if (gaps !== 0 || col_bad !== 0 || busy_bad !== 0 ||
          (n_exp > 0 && first_cyc !== 1))
         $display("FAIL %s_stream got first=%0d gaps=%0d colbad=%0d busybad=%0d want 1 0 0 0 (erase=%0b)",
                  name, first_cyc, gaps, col_bad, busy_bad, er);
      else passed++;
      total++;
      if (!hold_ok || !release_ok)
         $display("FAIL %s_handshake got hold=%0b release=%0b want 1 1", name, hold_ok, release_ok);
      else passed++;
   endtask

   task automatic test_box_4x3();
      logic [14:0] plan[10];
      plan = '{{8'd10,7'd20},{8'd11,7'd20},{8'd12,7'd20},{8'd13,7'd20},{8'd13,7'd21},
               {8'd13,7'd22},{8'd12,7'd22},{8'd11,7'd22},{8'd10,7'd22},{8'd10,7'd21}};
      exp_q.delete();
      foreach (plan[i]) exp_q.push_back(plan[i]);
      run_box(10, 13, 20, 22, 1'b0, 0, 0);
      check_run("box4x3", 10, 1'b0);
   endtask

   task automatic test_single_pixel();
      model_box(159, 159, 119, 119);
      run_box(159, 159, 119, 119, 1'b0, 0, 0);
      check_run("single", 1, 1'b0);
   endtask

   task automatic test_column_erase();
      model_box(0, 0, 0, 4);
      run_box(0, 0, 0, 4, 1'b1, 0, 0);
      check_run("column", 5, 1'b1);
   endtask

   task automatic test_invalid();
      model_box(50, 40, 10, 20);
      run_box(50, 40, 10, 20, 1'b0, 0, 0);
      check_run("inv_x", 0, 1'b0);
      model_box(5, 10, 100, 120);
      run_box(5, 10, 100, 120, 1'b0, 0, 0);
      check_run("inv_y", 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int nplot;
      @(negedge clk);
      xLeft = 8'd0; xRight = 8'd9; yTop = 7'd0; yBottom = 7'd9; erase = 1'b0; goDraw = 1'b1;
      nplot = 0;
      for (int k = 0; k < 20 && nplot < 5; k++) begin
         @(posedge clk); #1;
         if (plot) nplot++;
      end
      @(negedge clk); reset = 1'b1; goDraw = 1'b0;
      @(posedge clk); #1;
      total++;
      if (nplot !== 5 || {x, y, colour, plot, busy, doneDraw} !== 21'd0)
         $display("FAIL reset_mid got plots=%0d x=%0d y=%0d c=%0d p=%b b=%b d=%b want 5 and all 0",
                  nplot, x, y, colour, plot, busy, doneDraw);
      else passed++;
      @(negedge clk); reset = 1'b0;
      model_box(0, 9, 0, 9);
      total++;
      if (exp_q.size() !== 36)
         $display("FAIL model_count got %0d want 36", exp_q.size());
      else passed++;
      run_box(0, 9, 0, 9, 1'b0, 0, 0);
      check_run("after_reset", 36, 1'b0);
   endtask

   task automatic test_immunity();
      model_box(10, 13, 20, 22);
      run_box(10, 13, 20, 22, 1'b0, 3, 90);
      check_run("immunity", 10, 1'b0);
   endtask

   task automatic test_random();
      int xl, xr, yt, yb, n, w, h;
      bit er;
      for (int t = 0; t < 25; t++) begin
         xl = $urandom_range(0, 159); yt = $urandom_range(0, 119);
         xr = xl + $urandom_range(0, 30); yb = yt + $urandom_range(0, 20);
         if (xr > 159) xr = 159;
         if (yb > 119) yb = 119;
         case ($urandom_range(0, 7))
            0: begin n = xl; xl = xr + 1; xr = n; end
            1: yb = $urandom_range(120, 127);
            2: xr = $urandom_range(160, 255);
            default: ;
         endcase
         er = 1'($urandom_range(0, 1));
         if (xl > 255) xl = 255;
         model_box(xl, xr, yt, yb);
         w = xr - xl + 1; h = yb - yt + 1;
         if (xl > xr || yt > yb || xr > 159 || yb > 119) n = 0;
         else if (w == 1 || h == 1) n = w * h;
         else n = 2 * w + 2 * h - 4;
         total++;
         if (exp_q.size() !== n)
            $display("FAIL rand_model_count got %0d want %0d", exp_q.size(), n);
         else passed++;
         run_box(xl, xr, yt, yb, er, 0, 0);
         check_run($sformatf("rand%0d", t), n, er);
      end
   endtask

   initial begin
      test_reset();
      test_box_4x3();
      test_single_pixel();
      test_column_erase();
      test_invalid();
      test_reset_mid();
      test_immunity();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
